imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Inverse of the core's immediate-extraction logic: takes a 32-bit immediate, a format select and register/opcode fields, and assembles a 32-bit RV32I instruction word.
- Flags immediates that cannot be represented in the selected format.
- Buffers results in a 2-entry FIFO with valid/ready handshakes on both sides.
- Used by the debug instruction injector and by test stimulus generators that place instructions into the pipeline.

Parameters:
- CNT_W, 16, width of the encoded-instruction and error counters

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- immed_sel  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U; 101-111 reserved
- immed  in  32  immediate value, full sign-extended byte value as the decode side produces it
- opcode  in  7  instr[6:0]
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  instr[14:12]
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- instr  out  32  encoded instruction at FIFO head
- out_err  out  1  head entry had an unrepresentable immediate or reserved select
- enc_cnt  out  CNT_W  number of entries popped
- err_cnt  out  CNT_W  number of popped entries with out_err=1

Behaviour:
- Reset (asynchronous, immediate on assertion):
  - FIFO count = 0; out_valid = 0; instr = 0; out_err = 0; enc_cnt = err_cnt = 0.
  - in_ready = 0 while rst is high.
  - Asserting reset mid-operation discards all buffered entries.
- Encoding is combinational from the inputs. The entry (instr, err) is written into the FIFO at the accepting edge.
- Field placement, all formats: instr[6:0] = opcode.
  - I: [31:20]=immed[11:0]; [19:15]=rs1; [14:12]=funct3; [11:7]=rd.
  - S: [31:25]=immed[11:5]; [24:20]=rs2; [19:15]=rs1; [14:12]=funct3; [11:7]=immed[4:0].
  - B: [31]=immed[12]; [30:25]=immed[10:5]; [24:20]=rs2; [19:15]=rs1; [14:12]=funct3; [11:8]=immed[4:1]; [7]=immed[11].
  - J: [31]=immed[20]; [30:21]=immed[10:1]; [20]=immed[11]; [19:12]=immed[19:12]; [11:7]=rd.
  - U: [31:12]=immed[31:12]; [11:7]=rd.
- Representability; err=1 if violated:
  - I/S: immed[31:11] all equal.
  - B: immed[0]=0 and immed[31:12] all equal.
  - J: immed[0]=0 and immed[31:20] all equal.
  - U: immed[11:0]=0.
  - Reserved select: err=1 and instr=32'h0.
  - On err for a valid select, the instr field bits are still packed from the truncated immediate as listed above.
- Round-trip: for every non-error entry, re-extracting the immediate from instr with the same format returns immed exactly.
- Handshake:
  - Push when in_valid & in_ready; in_ready = ~rst & (count<2).
  - Pop when out_valid & out_ready; out_valid = (count>0).
  - Latency: request accepted at edge N → out_valid high after edge N, with zero bubble when the FIFO is empty.
  - Throughput: 1 per cycle when out_ready is held high.
- Simultaneous push and pop:
  - count 1: count stays 1; head advances to the new entry.
  - count 0: push only (no head yet).
  - count 2: no push (in_ready=0); pop only.
- Full (count=2): in_ready=0; in_valid is ignored and inputs may change freely.
- Empty: instr=0 and out_err=0 are driven (gated).
- While out_valid=1 and out_ready=0, instr and out_err are held stable.
- FIFO order is strictly preserved: 2-entry circular buffer, pointers wrap at 2.
- Counters:
  - enc_cnt increments on each pop; err_cnt increments on each pop with out_err=1.
  - Both wrap modulo 2^CNT_W and never saturate.

Test Plan:
- I-type: sel=000, immed=32'hFFFF_F800 (-2048), rs1=5, funct3=0, rd=1, opcode=7'h13 → instr=32'h8002_8093, err=0, out_valid one cycle after accept.
- B-type: sel=010, immed=32'h0000_0FFE, rs1=1, rs2=2, funct3=1, opcode=7'h63 → instr=32'h7E20_9FE3, err=0. Same request with immed=32'h0000_1001 → err=1.
- J/U: sel=011, immed=32'h000F_FFFE, rd=0, opcode=7'h6F → instr=32'h7FFF_F06F. sel=100, immed=32'h1234_5000, rd=3, opcode=7'h37 → instr=32'h1234_51B7. sel=100, immed=32'h0000_0001 → err=1.
- Backpressure: out_ready=0 with 3 back-to-back requests → in_ready drops after 2 accepts; then raise out_ready → the first two entries emerge in order, the third is accepted, and enc_cnt ends at 3.
- Simultaneous push/pop at count 1 for 10 cycles → out_valid held high, count stays 1, all 11 instructions in order, no drops.
- Reserved select 110 → instr=0, err=1, err_cnt=1 after pop. Reset asserted with 2 entries buffered → out_valid=0 immediately, counters=0, and after deassertion in_ready=1.

Source files
------------

// File: rtl/imm_encoder.sv
// RV32I instruction assembler: packs an immediate plus register/opcode fields
// into an instruction word and queues it in a 2-entry valid/ready FIFO.
module imm_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       immed_sel,
  input  logic [31:0]      immed,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned INSTR_W = 32;

  localparam logic [2:0] SEL_I = 3'b000;
  localparam logic [2:0] SEL_S = 3'b001;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_J = 3'b011;
  localparam logic [2:0] SEL_U = 3'b100;

  logic [INSTR_W-1:0] enc_instr_c;
  logic               enc_err_c;
  logic               sext11_ok_c;
  logic               sext12_ok_c;
  logic               sext20_ok_c;

  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic               mem_err   [DEPTH];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               push_c;
  logic               pop_c;

  // Upper immediate bits must be a pure sign extension of the field's MSB.
  assign sext11_ok_c = (&immed[31:11]) | ~(|immed[31:11]);
  assign sext12_ok_c = (&immed[31:12]) | ~(|immed[31:12]);
  assign sext20_ok_c = (&immed[31:20]) | ~(|immed[31:20]);

  always_comb begin
    enc_instr_c = '0;
    enc_err_c   = 1'b0;
    case (immed_sel)
      SEL_I: begin
        enc_instr_c = {immed[11:0], rs1, funct3, rd, opcode};
        enc_err_c   = ~sext11_ok_c;
      end
      SEL_S: begin
        enc_instr_c = {immed[11:5], rs2, rs1, funct3, immed[4:0], opcode};
        enc_err_c   = ~sext11_ok_c;
      end
      SEL_B: begin
        enc_instr_c = {immed[12], immed[10:5], rs2, rs1, funct3,
                       immed[4:1], immed[11], opcode};
        enc_err_c   = immed[0] | ~sext12_ok_c;
      end
      SEL_J: begin
        enc_instr_c = {immed[20], immed[10:1], immed[11], immed[19:12], rd, opcode};
        enc_err_c   = immed[0] | ~sext20_ok_c;
      end
      SEL_U: begin
        enc_instr_c = {immed[31:12], rd, opcode};
        enc_err_c   = |immed[11:0];
      end
      default: begin
        enc_instr_c = '0;
        enc_err_c   = 1'b1;
      end
    endcase
  end

  assign in_ready  = ~rst & (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push_c    = in_valid & in_ready;
  assign pop_c     = out_valid & out_ready;

  // Head is gated so an empty FIFO presents all-zero payload.
  assign instr   = out_valid ? mem_instr[rd_ptr] : '0;
  assign out_err = out_valid & mem_err[rd_ptr];

  // FIFO storage, pointers, occupancy and pop statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_err[i]   <= 1'b0;
      end
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      enc_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (push_c) begin
        mem_instr[wr_ptr] <= enc_instr_c;
        mem_err[wr_ptr]   <= enc_err_c;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop_c) begin
        rd_ptr  <= ~rd_ptr;
        enc_cnt <= enc_cnt + CNT_W'(1);
        if (mem_err[rd_ptr]) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
